// File: rtl/dmg_resolver_if.sv
// Request/response bundle between the battle control FSM and the damage resolver.
// The HP, KO and status signals also feed the HP displays.
interface dmg_resolver_if;
  logic       start;
  logic       target;
  logic [1:0] p_move;
  logic       dbg_roll_en;
  logic [3:0] dbg_roll;
  logic [3:0] p_hp;
  logic [3:0] ai_hp;
  logic [1:0] ai_move;
  logic       hit;
  logic       busy;
  logic       done;
  logic       p_ko;
  logic       ai_ko;

  modport master (
    output start, target, p_move, dbg_roll_en, dbg_roll,
    input  p_hp, ai_hp, ai_move, hit, busy, done, p_ko, ai_ko
  );

  modport slave (
    input  start, target, p_move, dbg_roll_en, dbg_roll,
    output p_hp, ai_hp, ai_move, hit, busy, done, p_ko, ai_ko
  );
endinterface

// File: rtl/dmg_resolver.sv
// Resolves one attack per request: move-table lookup, LFSR accuracy roll and saturating
// damage. Owns both HP registers.
module dmg_resolver #(
  parameter logic [3:0] P_HP_INIT  = 4'd9,
  parameter logic [3:0] AI_HP_INIT = 4'd5,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic           clk,
  input logic           rst,
  dmg_resolver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, RESOLVE, APPLY, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] p_hp_q, p_hp_d;
  logic [3:0] ai_hp_q, ai_hp_d;
  logic [1:0] ai_move_q, ai_move_d;
  logic [1:0] move_q, move_d;
  logic [3:0] roll_q, roll_d;
  logic [3:0] dmg_q, dmg_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] eff_dmg_q, eff_dmg_d;
  logic       target_q, target_d;
  logic       hit_int_q, hit_int_d;
  logic       hit_q, hit_d;
  logic [3:0] tgt_hp;
  logic [3:0] tgt_hp_new;
  logic       p_ko;
  logic       ai_ko;

  assign p_ko  = (p_hp_q == 4'd0);
  assign ai_ko = (ai_hp_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    p_hp_d     = p_hp_q;
    ai_hp_d    = ai_hp_q;
    ai_move_d  = ai_move_q;
    move_d     = move_q;
    roll_d     = roll_q;
    dmg_d      = dmg_q;
    acc_d      = acc_q;
    eff_dmg_d  = eff_dmg_q;
    target_d   = target_q;
    hit_int_d  = hit_int_q;
    hit_d      = hit_q;
    // The LFSR free-runs so AI moves and rolls depend on how long the player waited.
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    tgt_hp     = target_q ? p_hp_q : ai_hp_q;
    tgt_hp_new = (tgt_hp > eff_dmg_q) ? (tgt_hp - eff_dmg_q) : 4'd0;

    case (state_q)
      IDLE: begin
        if (bus.start && !p_ko && !ai_ko) begin
          target_d = bus.target;
          if (bus.target) begin
            move_d    = lfsr_q[5:4];
            ai_move_d = lfsr_q[5:4];
          end else begin
            move_d = bus.p_move;
          end
          roll_d  = bus.dbg_roll_en ? bus.dbg_roll : lfsr_q[3:0];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        case (move_q)
          2'd0:    begin dmg_d = 4'd2; acc_d = 4'd15; end
          2'd1:    begin dmg_d = 4'd4; acc_d = 4'd11; end
          2'd2:    begin dmg_d = 4'd6; acc_d = 4'd7;  end
          default: begin dmg_d = 4'd9; acc_d = 4'd3;  end
        endcase
        state_d = RESOLVE;
      end
      RESOLVE: begin
        hit_int_d = (roll_q <= acc_q);
        eff_dmg_d = hit_int_d ? dmg_q : 4'd0;
        state_d   = APPLY;
      end
      APPLY: begin
        hit_d = hit_int_q;
        if (target_q) begin
          p_hp_d = tgt_hp_new;
        end else begin
          ai_hp_d = tgt_hp_new;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      p_hp_q    <= P_HP_INIT;
      ai_hp_q   <= AI_HP_INIT;
      ai_move_q <= 2'd0;
      move_q    <= 2'd0;
      roll_q    <= 4'd0;
      dmg_q     <= 4'd0;
      acc_q     <= 4'd0;
      eff_dmg_q <= 4'd0;
      target_q  <= 1'b0;
      hit_int_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      p_hp_q    <= p_hp_d;
      ai_hp_q   <= ai_hp_d;
      ai_move_q <= ai_move_d;
      move_q    <= move_d;
      roll_q    <= roll_d;
      dmg_q     <= dmg_d;
      acc_q     <= acc_d;
      eff_dmg_q <= eff_dmg_d;
      target_q  <= target_d;
      hit_int_q <= hit_int_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.p_hp    = p_hp_q;
  assign bus.ai_hp   = ai_hp_q;
  assign bus.ai_move = ai_move_q;
  assign bus.hit     = hit_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.p_ko    = p_ko;
  assign bus.ai_ko   = ai_ko;

endmodule
